// File: rtl/alu_operand_stage.sv
// ---------------------------------------------------------------------------
// alu_operand_stage
//
// Operand-issue stage that sits directly in front of ALU16bit. It owns the
// 2**ADDR_W x DATA_W register file (r0 hardwired to zero). It accepts one
// decoded ALU instruction per cycle into a single registered EX slot and
// drives aluOp/aIn/bIn from that slot. The combinational ALU result comes
// back on aluResult and is written into the register file when the EX
// instruction retires. The same result is forwarded to the instruction being
// issued in that cycle, so dependent instructions issue back to back.
//
// Handshakes (valid/ready):
//   issue side : the instruction transfers on a cycle with
//                issueValid && issueReady. The upstream holds its inputs
//                stable while issueValid && !issueReady.
//   EX side    : the EX instruction retires on a cycle with
//                exValid && exReady. The slot stays frozen while
//                exValid && !exReady.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   issueValid/Ready     issue handshake
//   issueOp              ALU opcode, passed through without interpretation
//   rsAddr/rtAddr/rdAddr source and destination register addresses
//   useImm/immVal        selects immVal as the B operand instead of reg[rt]
//   aluOp/aIn/bIn        registered operands to ALU16bit
//   exValid/exReady      EX-slot handshake
//   aluResult            ALU16bit output for the current aluOp/aIn/bIn
//   dbgAddr/dbgData      combinational debug read of the register file
//   retireCount          wrapping count of retired instructions
// ---------------------------------------------------------------------------
module alu_operand_stage #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issueValid,
    output logic              issueReady,
    input  logic [3:0]        issueOp,
    input  logic [ADDR_W-1:0] rsAddr,
    input  logic [ADDR_W-1:0] rtAddr,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic              useImm,
    input  logic [DATA_W-1:0] immVal,
    output logic [3:0]        aluOp,
    output logic [DATA_W-1:0] aIn,
    output logic [DATA_W-1:0] bIn,
    output logic              exValid,
    input  logic              exReady,
    input  logic [DATA_W-1:0] aluResult,
    input  logic [ADDR_W-1:0] dbgAddr,
    output logic [DATA_W-1:0] dbgData,
    output logic [15:0]       retireCount
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] rf_q [NREG];
    logic              ex_valid_q;
    logic [3:0]        alu_op_q;
    logic [DATA_W-1:0] a_in_q;
    logic [DATA_W-1:0] b_in_q;
    logic [ADDR_W-1:0] ex_rd_q;
    logic [15:0]       retire_cnt_q;

    logic              accept;
    logic              retire;
    logic              rf_we;
    logic [DATA_W-1:0] a_in_d;
    logic [DATA_W-1:0] b_in_d;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    assign issueReady = !ex_valid_q || exReady;
    assign accept     = issueValid && issueReady;
    assign retire     = ex_valid_q && exReady;
    // Retires to r0 still count but never touch the register file.
    assign rf_we      = retire && (ex_rd_q != '0);

    // Operand read with bypass of the result retiring this cycle. r0 is
    // never written, so rf_q[0] stays zero. Requiring a write enable for the
    // bypass also keeps a retire to r0 from leaking into an r0 read.
    always_comb begin
        rs_fwd = rf_q[rsAddr];
        rt_fwd = rf_q[rtAddr];
        if (rf_we && (ex_rd_q == rsAddr)) begin
            rs_fwd = aluResult;
        end
        if (rf_we && (ex_rd_q == rtAddr)) begin
            rt_fwd = aluResult;
        end
        a_in_d = rs_fwd;
        b_in_d = useImm ? immVal : rt_fwd;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid_q   <= 1'b0;
            alu_op_q     <= '0;
            a_in_q       <= '0;
            b_in_q       <= '0;
            ex_rd_q      <= '0;
            retire_cnt_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            if (rf_we) begin
                rf_q[ex_rd_q] <= aluResult;
            end
            if (retire) begin
                retire_cnt_q <= retire_cnt_q + 16'd1;
            end
            if (accept) begin
                ex_valid_q <= 1'b1;
                alu_op_q   <= issueOp;
                a_in_q     <= a_in_d;
                b_in_q     <= b_in_d;
                ex_rd_q    <= rdAddr;
            end else if (retire) begin
                // Operands keep their last values; only the slot empties.
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign exValid     = ex_valid_q;
    assign aluOp       = alu_op_q;
    assign aIn         = a_in_q;
    assign bIn         = b_in_q;
    assign retireCount = retire_cnt_q;
    assign dbgData     = (dbgAddr == '0) ? '0 : rf_q[dbgAddr];

endmodule

// File: tb/tb_alu_operand_stage.sv
module tb_alu_operand_stage;

  logic        clk;
  logic        reset;
  logic        issueValid;
  logic        issueReady;
  logic [3:0]  issueOp;
  logic [3:0]  rsAddr;
  logic [3:0]  rtAddr;
  logic [3:0]  rdAddr;
  logic        useImm;
  logic [15:0] immVal;
  logic [3:0]  aluOp;
  logic [15:0] aIn;
  logic [15:0] bIn;
  logic        exValid;
  logic        exReady;
  logic [15:0] aluResult;
  logic [3:0]  dbgAddr;
  logic [15:0] dbgData;
  logic [15:0] retireCount;

  int n_cmp;
  int n_err;

  alu_operand_stage #(.DATA_W(16), .ADDR_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .issueValid (issueValid),
    .issueReady (issueReady),
    .issueOp    (issueOp),
    .rsAddr     (rsAddr),
    .rtAddr     (rtAddr),
    .rdAddr     (rdAddr),
    .useImm     (useImm),
    .immVal     (immVal),
    .aluOp      (aluOp),
    .aIn        (aIn),
    .bIn        (bIn),
    .exValid    (exValid),
    .exReady    (exReady),
    .aluResult  (aluResult),
    .dbgAddr    (dbgAddr),
    .dbgData    (dbgData),
    .retireCount(retireCount)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Small ALU16bit stand-in for the opcodes used below: ADD, SUB, SLL.
  always_comb begin
    case (aluOp)
      4'b0001: aluResult = aIn - bIn;
      4'b0101: aluResult = aIn << bIn[3:0];
      default: aluResult = aIn + bIn;
    endcase
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                       input logic [3:0] rt, input logic imm_sel, input logic [15:0] imm);
    issueValid = 1'b1;
    issueOp    = op;
    rdAddr     = rd;
    rsAddr     = rs;
    rtAddr     = rt;
    useImm     = imm_sel;
    immVal     = imm;
  endtask

  task automatic idle();
    issueValid = 1'b0;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [3:0] addr, input logic [15:0] exp);
    dbgAddr = addr;
    #1;
    chk(tag, {16'd0, dbgData}, {16'd0, exp});
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    reset      = 1'b0;
    issueValid = 1'b0;
    issueOp    = 4'd0;
    rsAddr     = 4'd0;
    rtAddr     = 4'd0;
    rdAddr     = 4'd0;
    useImm     = 1'b0;
    immVal     = 16'd0;
    exReady    = 1'b1;
    dbgAddr    = 4'd0;

    // ---- reset state
    repeat (2) tick();
    chk("rst_exValid", {31'd0, exValid}, 32'd0);
    chk("rst_aluOp", {28'd0, aluOp}, 32'd0);
    chk("rst_aIn", {16'd0, aIn}, 32'd0);
    chk("rst_bIn", {16'd0, bIn}, 32'd0);
    chk("rst_count", {16'd0, retireCount}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_issueReady", {31'd0, issueReady}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk_reg($sformatf("rst_r%0d", i), 4'(i), 16'd0);
    end

    // ---- forward chain: r1 = 0+13, r2 = r1+24
    tick();
    issue(4'b0000, 4'd1, 4'd0, 4'd0, 1'b1, 16'd13);
    tick();
    chk("fc1_exValid", {31'd0, exValid}, 32'd1);
    chk("fc1_aIn", {16'd0, aIn}, 32'd0);
    chk("fc1_bIn", {16'd0, bIn}, 32'd13);
    issue(4'b0000, 4'd2, 4'd1, 4'd0, 1'b1, 16'd24);
    tick();
    chk("fc2_aIn_fwd", {16'd0, aIn}, 32'd13);
    chk("fc2_bIn", {16'd0, bIn}, 32'd24);
    idle();
    tick();
    chk("fc_exValid_drained", {31'd0, exValid}, 32'd0);
    chk("fc_count", {16'd0, retireCount}, 32'd2);
    chk_reg("fc_r1", 4'd1, 16'd13);
    chk_reg("fc_r2", 4'd2, 16'd37);

    // ---- stall: r1 = 1, then SLL r4 = r1 << 3 held with exReady=0
    issue(4'b0000, 4'd1, 4'd0, 4'd0, 1'b1, 16'd1);
    tick();
    issue(4'b0101, 4'd4, 4'd1, 4'd0, 1'b1, 16'd3);
    tick();
    exReady = 1'b0;
    issue(4'b0000, 4'd7, 4'd4, 4'd0, 1'b1, 16'd2);
    #1;
    chk("st_issueReady", {31'd0, issueReady}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("st%0d_aluOp", i), {28'd0, aluOp}, 32'h5);
      chk($sformatf("st%0d_aIn", i), {16'd0, aIn}, 32'd1);
      chk($sformatf("st%0d_bIn", i), {16'd0, bIn}, 32'd3);
      chk($sformatf("st%0d_exValid", i), {31'd0, exValid}, 32'd1);
      chk($sformatf("st%0d_count", i), {16'd0, retireCount}, 32'd3);
      chk_reg($sformatf("st%0d_r4", i), 4'd4, 16'd0);
    end
    exReady = 1'b1;
    #1;
    chk("st_rel_issueReady", {31'd0, issueReady}, 32'd1);
    tick();
    chk_reg("st_r4", 4'd4, 16'd8);
    chk("st_count", {16'd0, retireCount}, 32'd4);
    chk("st_queued_aluOp", {28'd0, aluOp}, 32'h0);
    chk("st_queued_aIn", {16'd0, aIn}, 32'd8);
    chk("st_queued_bIn", {16'd0, bIn}, 32'd2);
    idle();
    tick();
    chk_reg("st_r7", 4'd7, 16'd10);
    chk("st_count2", {16'd0, retireCount}, 32'd5);

    // ---- rt forwarding: r5 = 15, r6 = r0 - r5
    issue(4'b0000, 4'd5, 4'd0, 4'd0, 1'b1, 16'd15);
    tick();
    issue(4'b0001, 4'd6, 4'd0, 4'd5, 1'b0, 16'hBEEF);
    tick();
    chk("rt_aluOp", {28'd0, aluOp}, 32'h1);
    chk("rt_aIn", {16'd0, aIn}, 32'd0);
    chk("rt_bIn_fwd", {16'd0, bIn}, 32'd15);
    idle();
    tick();
    chk_reg("rt_r5", 4'd5, 16'd15);
    chk_reg("rt_r6", 4'd6, 16'hFFF1);
    chk("rt_count", {16'd0, retireCount}, 32'd7);

    // ---- r0 write is dropped but counted; the next rs=0 reads zero
    issue(4'b0000, 4'd0, 4'd0, 4'd0, 1'b1, 16'd5);
    tick();
    issue(4'b0000, 4'd8, 4'd0, 4'd0, 1'b1, 16'd1);
    tick();
    chk("r0_next_aIn", {16'd0, aIn}, 32'd0);
    chk("r0_next_bIn", {16'd0, bIn}, 32'd1);
    chk_reg("r0_dbg", 4'd0, 16'd0);
    idle();
    tick();
    chk("r0_count", {16'd0, retireCount}, 32'd9);
    chk_reg("r0_r8", 4'd8, 16'd1);

    // ---- reset while the EX slot is stalled
    exReady = 1'b0;
    issue(4'b0000, 4'd9, 4'd5, 4'd0, 1'b1, 16'd1);
    tick();
    idle();
    chk("rm_exValid_pre", {31'd0, exValid}, 32'd1);
    chk("rm_aIn_pre", {16'd0, aIn}, 32'd15);
    #2;
    reset = 1'b0;
    #1;
    chk("rm_exValid", {31'd0, exValid}, 32'd0);
    chk("rm_aluOp", {28'd0, aluOp}, 32'd0);
    chk("rm_aIn", {16'd0, aIn}, 32'd0);
    chk("rm_bIn", {16'd0, bIn}, 32'd0);
    chk("rm_count", {16'd0, retireCount}, 32'd0);
    chk_reg("rm_r5", 4'd5, 16'd0);
    chk_reg("rm_r6", 4'd6, 16'd0);
    tick();
    reset   = 1'b1;
    exReady = 1'b1;
    repeat (2) tick();
    chk("rm_post_exValid", {31'd0, exValid}, 32'd0);
    chk("rm_post_count", {16'd0, retireCount}, 32'd0);
    chk_reg("rm_post_r9", 4'd9, 16'd0);
    chk_reg("rm_post_r5", 4'd5, 16'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Operand-issue stage directly upstream of ALU16bit; owns the 16 x 16-bit register file.
- Accepts decoded ALU instructions and presents aluOp/aIn/bIn from a single-entry registered EX slot.
- Retires the combinational ALU result back into the register file, with same-cycle forwarding to the next issued instruction.

Parameters:
DATA_W, 16, operand/result width (matches ALU16bit)
ADDR_W, 4, register address width; 2**ADDR_W registers, r0 hardwired to zero

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
issueValid  input  1  decoded instruction offered
issueReady  output  1  stage can accept the offered instruction this cycle
issueOp  input  4  ALU opcode (ALU16bit encoding: 0000 ADD … 1111 SLT)
rsAddr  input  ADDR_W  source register for aIn
rtAddr  input  ADDR_W  source register for bIn when useImm=0
rdAddr  input  ADDR_W  destination register
useImm  input  1  1: bIn = immVal; 0: bIn = reg[rtAddr]
immVal  input  DATA_W  immediate operand / shift amount
aluOp  output  4  to ALU16bit.aluOp (registered)
aIn  output  DATA_W  to ALU16bit.aIn (registered)
bIn  output  DATA_W  to ALU16bit.bIn (registered)
exValid  output  1  EX slot holds a live instruction
exReady  input  1  downstream accepts/retires the EX instruction this cycle
aluResult  input  DATA_W  ALU16bit.outPut for current aluOp/aIn/bIn
dbgAddr  input  ADDR_W  debug read address
dbgData  output  DATA_W  combinational reg[dbgAddr], r0 reads 0
retireCount  output  16  count of retired instructions, wraps

Behaviour:
- Reset (reset=0, async) clears: exValid=0, aluOp=0, aIn=0, bIn=0, internal exRd=0, all registers=0, retireCount=0. issueReady=1 once reset is deasserted.
- Reset mid-operation drops the in-flight EX instruction. There is no commit and no count.
- issueReady = !exValid || exReady (combinational).
- accept = issueValid && issueReady.
- retire = exValid && exReady.
- On retire:
  - reg[exRd] <= aluResult unless exRd==0 (write suppressed).
  - retireCount += 1, including rd=0 retires; 16'hFFFF wraps to 0.
- On accept:
  - aluOp <= issueOp; exRd <= rdAddr; exValid <= 1.
  - aIn <= fwd(rsAddr).
  - bIn <= useImm ? immVal : fwd(rtAddr).
- Forwarding: fwd(a) = (retire && exRd==a && a!=0) ? aluResult : reg[a]. r0 always yields 0. No stale read, so a back-to-back dependent pair issues at one per cycle.
- On retire without accept: exValid <= 0. aluOp/aIn/bIn hold their last values.
- While exValid && !exReady: aluOp, aIn, bIn and exRd are frozen. No register write, no count.
- Latency:
  - Instruction accepted in cycle N appears on aluOp/aIn/bIn and exValid in cycle N+1.
  - Earliest retire is cycle N+1; its result is visible on dbgData from cycle N+2.
- Throughput: 1 instruction/cycle when exReady is held 1.
- issueValid with !issueReady: nothing is captured. The upstream must hold its inputs.
- All ALU opcodes retire identically, including EQ0/SLT. Operands are not interpreted.
- Width: all data paths are DATA_W. No truncation except the retireCount wrap.

Test Plan:
- Reset: pulse reset low mid-clock -> exValid/aIn/bIn/aluOp=0 immediately (async). issueReady=1 after release. dbgData=0 for addrs 0..15. retireCount=0.
- Forward chain (exReady=1):
  - Cycle 0: ADD rd=1 rs=0 useImm imm=13.
  - Cycle 1: ADD rd=2 rs=1 useImm imm=24 -> cycle 1 aIn=0, bIn=13. Cycle 2 aIn=13 (forwarded), bIn=24.
  - Afterwards: dbg r1=13, r2=37, retireCount=2.
- Stall:
  - Issue SLL rd=4 rs=r1(=1) imm=3, then hold exReady=0 for 3 cycles with issueValid=1 -> issueReady=0, aluOp=0101, aIn=1, bIn=3 stable, no write, count unchanged.
  - Release: r4=8 next cycle; the queued instruction is captured in the same cycle.
- rt forwarding: r5=15 via ADD imm, then SUB rd=6 rs=0 rt=5 useImm=0 back-to-back -> bIn=15, r6=16'hFFF1.
- r0 write: ADD rd=0 rs=0 imm=5 -> retire increments retireCount, dbg r0 stays 0. A following ADD rs=0 sees aIn=0.
- Reset mid-op: exValid=1, exReady=0, assert reset -> exValid=0 and all registers 0. After release, no commit of the dropped instruction occurs.
